// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end. At most one memory request is in
// flight, and a small in-order buffer feeds the decoder. A new request is
// issued only when the buffer is guaranteed room for its response.
// Optional feature: define FETCH_MISALIGN_TRAP_EN to trap on redirect targets
// that are not word aligned; this adds the misalign_err port.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clock,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        halt
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        misalign_err
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  // S_REQ: wants to fetch (imem_req high when credit allows)
  // S_WAIT: one request outstanding, response will be buffered
  // S_DISCARD: one request outstanding, response is stale after a redirect
  // S_HALTED: terminal until reset
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DISCARD, S_HALTED} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } entry_t;

  state_t                  state, state_n;
  logic [31:0]             fetch_pc, pc_n, req_pc, tgt;
  entry_t [FIFO_DEPTH-1:0] fifo_q;
  logic [PW-1:0]           rd_ptr, wr_ptr;
  logic [CW-1:0]           count, count_n;
  logic                    accept, push, pop, req_n, bad_tgt;

  // imem_addr is the fetch_pc register itself, so it only moves on an
  // accept or a redirect and stays stable while a request waits.
  assign imem_addr  = fetch_pc;
  assign inst_valid = (count != '0);
  assign inst_data  = fifo_q[rd_ptr].data;
  assign inst_pc    = fifo_q[rd_ptr].pc;

  assign accept = imem_req & imem_ready;
  // Redirect outranks buffer traffic: a same-cycle response or pop is void.
  assign push   = imem_rvalid & (state == S_WAIT) & ~redirect_valid;
  assign pop    = inst_valid & inst_ready & ~redirect_valid;
  assign tgt    = redirect_target & ~32'h3;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign bad_tgt = redirect_valid & (redirect_target[1:0] != 2'b00);

  // Sticky misalignment flag, cleared only by reset
  always_ff @(posedge clock or posedge rst) begin
    if (rst)          misalign_err <= 1'b0;
    else if (bad_tgt) misalign_err <= 1'b1;
  end
`else
  assign bad_tgt = 1'b0;
`endif

  // Buffer occupancy after this edge
  always_comb begin
    count_n = count;
    if (redirect_valid)     count_n = '0;
    else if (push && !pop)  count_n = count + CW'(1);
    else if (pop && !push)  count_n = count - CW'(1);
  end

  // Next state, next fetch address and next request
  always_comb begin
    state_n = state;
    pc_n    = fetch_pc;
    if (accept) pc_n = fetch_pc + 32'd4;
    case (state)
      S_REQ: begin
        if (accept)                 state_n = S_WAIT;
        else if (halt && !imem_req) state_n = S_HALTED;
      end
      S_WAIT, S_DISCARD: begin
        if (imem_rvalid) state_n = halt ? S_HALTED : S_REQ;
      end
      default: state_n = state;
    endcase
    if (bad_tgt) begin
      state_n = S_HALTED;
    end else if (redirect_valid && state != S_HALTED) begin
      pc_n = tgt;
      // A request accepted on this very edge is in flight and must be
      // discarded; a response landing on this edge closes the transaction.
      if (state == S_REQ) state_n = accept ? S_DISCARD : S_REQ;
      else                state_n = imem_rvalid ? S_REQ : S_DISCARD;
    end
    // Credit: nothing is outstanding in S_REQ, so room in the buffer is
    // enough. Halt blocks new requests but a presented one stays presented.
    req_n = (state_n == S_REQ) && (count_n < DEPTH_C) &&
            (!halt || (imem_req && !accept));
  end

  // Control registers
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state    <= S_REQ;
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      imem_req <= 1'b0;
    end else begin
      state    <= state_n;
      fetch_pc <= pc_n;
      imem_req <= req_n;
      if (accept) req_pc <= fetch_pc;
    end
  end

  // Instruction buffer: circular, flushed by redirect
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      fifo_q <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      count <= count_n;
      if (redirect_valid) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) begin
          fifo_q[wr_ptr] <= '{pc: req_pc, data: imem_rdata};
          wr_ptr         <= wr_ptr + PW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: drives fetch_unit with a memory model of configurable
// latency and checks the decoder stream against the program-order rule:
// consecutive words from reset PC or the latest redirect target.
module tb_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req, imem_ready, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        inst_valid, inst_ready;
  logic [31:0] inst_data, inst_pc;
  logic        redirect_valid, halt;
  logic [31:0] redirect_target;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misalign_err;
`endif

  always #5 clock = ~clock;

  fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(2)) dut (
    .clock(clock), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .halt(halt)
`ifdef FETCH_MISALIGN_TRAP_EN
    , .misalign_err(misalign_err)
`endif
  );

  int          checks = 0, errors = 0;
  // memory model
  logic        mem_pend;
  logic [31:0] mem_addr;
  int          mem_lat, lat_min, lat_max;
  bit          rand_ready, spur_en, spur_once;
  logic [31:0] key;
  // reference stream
  logic [31:0] exp_pc, exp_req;
  int          cons_cnt, acc_cnt;
  logic [31:0] last_cons_pc, last_acc_addr;
  logic        hold_prev;
  logic [31:0] hold_addr;

  task automatic model_clear();
    mem_pend = 1'b0; mem_lat = 0;
    exp_pc = RST_PC; exp_req = RST_PC;
    cons_cnt = 0; acc_cnt = 0; hold_prev = 1'b0;
    last_cons_pc = '1; last_acc_addr = '1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    inst_ready = 1'b0; redirect_valid = 1'b0; redirect_target = '0; halt = 1'b0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    rand_ready = 1'b0; spur_en = 1'b0; spur_once = 1'b0; key = '0;
    lat_min = 0; lat_max = 0;
    repeat (2) @(negedge clock);
    model_clear();
    rst = 1'b0;
  endtask

  // One clock: drive memory, score the handshakes of the coming edge.
  task automatic tick();
    logic acc, con;
    logic [31:0] a;
    imem_ready  = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (mem_pend && mem_lat == 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_addr ^ key;
    end else if (!mem_pend && (spur_once || (spur_en && $urandom_range(0, 7) == 0))) begin
      imem_rvalid = 1'b1;
      spur_once   = 1'b0;
    end
    if (hold_prev) begin
      checks++;
      if (!(imem_req === 1'b1 && imem_addr === hold_addr)) begin
        errors++;
        $display("FAIL req_stable got req=%0b addr=%h want req=1 addr=%h", imem_req, imem_addr, hold_addr);
      end
    end
    if (imem_req && mem_pend) begin
      checks++; errors++;
      $display("FAIL one_outstanding got req=1 while pending want req=0");
    end
    acc = imem_req && imem_ready;
    a   = imem_addr;
    con = inst_valid && inst_ready && !redirect_valid;
    if (acc) begin
      checks++;
      if (a !== exp_req) begin
        errors++;
        $display("FAIL req_addr got %h want %h", a, exp_req);
      end
      exp_req = exp_req + 32'd4;
      acc_cnt++; last_acc_addr = a;
    end
    if (con) begin
      checks++;
      if (inst_pc !== exp_pc || inst_data !== (exp_pc ^ key)) begin
        errors++;
        $display("FAIL inst got pc=%h data=%h want pc=%h data=%h", inst_pc, inst_data, exp_pc, exp_pc ^ key);
      end
      exp_pc = exp_pc + 32'd4;
      cons_cnt++; last_cons_pc = inst_pc;
    end
    if (redirect_valid) begin
      exp_pc  = redirect_target & ~32'h3;
      exp_req = exp_pc;
    end
    hold_prev = imem_req && !imem_ready && !redirect_valid;
    hold_addr = imem_addr;
    @(posedge clock);
    if (imem_rvalid && mem_pend) mem_pend = 1'b0;
    else if (mem_pend && mem_lat > 0) mem_lat--;
    if (acc) begin
      mem_pend = 1'b1; mem_addr = a;
      mem_lat  = $urandom_range(lat_max, lat_min);
    end
    @(negedge clock);
  endtask

  task automatic wait_pend_addr(input logic [31:0] addr, input string nm);
    int n = 0;
    while (!(mem_pend && mem_addr == addr) && n < 60) begin tick(); n++; end
    checks++;
    if (!(mem_pend && mem_addr == addr)) begin
      errors++;
      $display("FAIL %s timeout got pend=%0b addr=%h want pend=1 addr=%h", nm, mem_pend, mem_addr, addr);
    end
  endtask

  task automatic wait_consume(output logic [31:0] pc);
    int c0 = cons_cnt, n = 0;
    while (cons_cnt == c0 && n < 60) begin tick(); n++; end
    pc = (cons_cnt == c0) ? 32'hDEAD_BEEF : last_cons_pc;
  endtask

  task automatic test_reset();
    do_reset();
    inst_ready = 1'b1; lat_min = 2; lat_max = 2;
    wait_pend_addr(RST_PC + 32'd4, "reset_pend");
    #2 rst = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b0 || inst_valid !== 1'b0 || imem_addr !== RST_PC ||
        inst_pc !== 32'h0 || inst_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_state got req=%0b vld=%0b addr=%h pc=%h data=%h want 0 0 %h 0 0",
               imem_req, inst_valid, imem_addr, inst_pc, inst_data, RST_PC);
    end
    repeat (2) @(negedge clock);
    model_clear();
    rst = 1'b0;
    spur_once = 1'b1;  // stale response arriving after reset
    tick();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin
      errors++;
      $display("FAIL first_req got req=%0b addr=%h want req=1 addr=%h", imem_req, imem_addr, RST_PC);
    end
    repeat (20) tick();
    checks++;
    if (cons_cnt < 3) begin
      errors++;
      $display("FAIL reset_restart got %0d want >=3", cons_cnt);
    end
  endtask

  task automatic test_stream();
    int c0;
    do_reset();
    inst_ready = 1'b1;
    repeat (10) tick();
    c0 = cons_cnt;
    repeat (40) tick();
    checks++;
    if (cons_cnt - c0 != 20) begin
      errors++;
      $display("FAIL throughput got %0d want 20", cons_cnt - c0);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    repeat (10) tick();
    checks++;
    if (acc_cnt != 2 || imem_req !== 1'b0 || inst_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_full got acc=%0d req=%0b vld=%0b want acc=2 req=0 vld=1", acc_cnt, imem_req, inst_valid);
    end
    inst_ready = 1'b1;
    repeat (2) tick();
    checks++;
    if (cons_cnt != 2 || last_cons_pc !== 32'h4) begin
      errors++;
      $display("FAIL bp_drain got n=%0d pc=%h want n=2 pc=00000004", cons_cnt, last_cons_pc);
    end
    repeat (10) tick();
  endtask

  task automatic test_redirect();
    logic [31:0] pc;
    do_reset();
    inst_ready = 1'b1; lat_min = 2; lat_max = 2;
    wait_pend_addr(32'h8, "redir_pend");
    redirect_valid = 1'b1; redirect_target = 32'h100;
    tick();
    redirect_valid = 1'b0;
    wait_consume(pc);
    checks++;
    if (pc !== 32'h100) begin
      errors++;
      $display("FAIL redirect_first got %h want 00000100", pc);
    end
    repeat (10) tick();
  endtask

  task automatic test_wrap();
    int c0;
    do_reset();
    inst_ready = 1'b1;
    repeat (4) tick();
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFF8;
    tick();
    redirect_valid = 1'b0;
    c0 = cons_cnt;
    repeat (12) tick();
    checks++;
    if (cons_cnt - c0 < 4) begin
      errors++;
      $display("FAIL wrap got %0d want >=4", cons_cnt - c0);
    end
  endtask

  task automatic test_halt();
    int a0;
    logic [31:0] pa;
    do_reset();
    inst_ready = 1'b1; lat_min = 2; lat_max = 2;
    wait_pend_addr(32'h8, "halt_pend");
    pa = mem_addr;
    halt = 1'b1;
    a0 = acc_cnt;
    repeat (20) tick();
    checks++;
    if (acc_cnt != a0 || last_cons_pc !== pa || imem_req !== 1'b0 || inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL halt got acc=%0d last=%h req=%0b vld=%0b want acc=%0d last=%h req=0 vld=0",
               acc_cnt, last_cons_pc, imem_req, inst_valid, a0, pa);
    end
    halt = 1'b0;
    repeat (8) tick();
    checks++;
    if (acc_cnt != a0 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL halted_sticky got acc=%0d req=%0b want acc=%0d req=0", acc_cnt, imem_req, a0);
    end
  endtask

  task automatic test_misalign();
    int a0;
    do_reset();
    inst_ready = 1'b1; lat_min = 1; lat_max = 1;
    repeat (6) tick();
    redirect_valid = 1'b1; redirect_target = 32'h102;
    tick();
    redirect_valid = 1'b0;
    a0 = acc_cnt;
`ifdef FETCH_MISALIGN_TRAP_EN
    checks++;
    if (misalign_err !== 1'b1 || inst_valid !== 1'b0 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL misalign got err=%0b vld=%0b req=%0b want 1 0 0", misalign_err, inst_valid, imem_req);
    end
    repeat (10) tick();
    checks++;
    if (acc_cnt != a0 || imem_req !== 1'b0 || misalign_err !== 1'b1) begin
      errors++;
      $display("FAIL misalign_halt got acc=%0d req=%0b err=%0b want acc=%0d req=0 err=1",
               acc_cnt, imem_req, misalign_err, a0);
    end
`else
    begin
      int n = 0;
      while (acc_cnt == a0 && n < 20) begin tick(); n++; end
    end
    checks++;
    if (acc_cnt == a0 || last_acc_addr !== 32'h100) begin
      errors++;
      $display("FAIL misalign_fetch got acc=%0d addr=%h want addr=00000100", acc_cnt - a0, last_acc_addr);
    end
    repeat (10) tick();
`endif
  endtask

  task automatic test_random();
    int c0;
    do_reset();
    key = 32'h5A5A_1234; lat_min = 0; lat_max = 3; rand_ready = 1'b1; spur_en = 1'b1;
    c0 = cons_cnt;
    for (int i = 0; i < 800; i++) begin
      inst_ready     = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 24) == 0);
      redirect_target = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                     : $urandom;
`ifdef FETCH_MISALIGN_TRAP_EN
      redirect_target = redirect_target & ~32'h3;
`endif
      tick();
    end
    redirect_valid = 1'b0;
    checks++;
    if (cons_cnt - c0 < 50) begin
      errors++;
      $display("FAIL random_progress got %0d want >=50", cons_cnt - c0);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_halt();
    test_misalign();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2: instruction buffer entries; legal values 2 or 4.
REQ-003 SHALL have port clock, input, 1: sole clock, all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port imem_req, output, 1: fetch request valid.
REQ-006 SHALL have port imem_addr, output, 32: word address of the request.
REQ-007 SHALL have port imem_ready, input, 1: memory accepts the request when high with imem_req.
REQ-008 SHALL have port imem_rvalid, input, 1: response data valid.
REQ-009 SHALL have port imem_rdata, input, 32: returned instruction word.
REQ-010 SHALL have port inst_valid, output, 1: buffer head holds an instruction for the decoder.
REQ-011 SHALL have port inst_ready, input, 1: decoder consumes the head when high with inst_valid.
REQ-012 SHALL have port inst_data, output, 32: head instruction.
REQ-013 SHALL have port inst_pc, output, 32: address of the head instruction.
REQ-014 SHALL have port redirect_valid, input, 1: taken branch or jump.
REQ-015 SHALL have port redirect_target, input, 32: new fetch address.
REQ-016 SHALL have port halt, input, 1: finish_flag from the core; stops new requests.
REQ-017 SHALL have port misalign_err, output, 1: present only under FETCH_MISALIGN_TRAP_EN.

Function
REQ-018 SHALL run FSM states REQ (imem_req=1), WAIT (one request outstanding), DISCARD (outstanding response stale), HALTED.
REQ-019 SHALL keep at most one request outstanding; imem_req and imem_addr registered, stable until accepted.
REQ-020 SHALL enter REQ only when fifo_count + outstanding < FIFO_DEPTH (credit check); no response is ever dropped for lack of space.
REQ-021 REQ -> WAIT on imem_req&imem_ready; fetch_pc += 4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0).
REQ-022 WAIT -> REQ (credit available) or idle-wait (no credit) on imem_rvalid; {imem_rdata, request pc} pushed, visible on inst_valid the next cycle.
REQ-023 Steady-state throughput with single-cycle memory: one instruction per 2 cycles.
REQ-024 Pop on inst_valid&inst_ready; push and pop in same cycle permitted, count unchanged.
REQ-025 Redirect: same edge flushes FIFO, fetch_pc <= redirect_target, inst_valid=0 next cycle; REQ not yet accepted re-issues with new address; outstanding request -> DISCARD.
REQ-026 DISCARD: imem_rvalid data dropped, then -> REQ at redirect target; a further redirect in DISCARD only updates fetch_pc.
REQ-027 Redirect has priority over simultaneous push, pop and halt.
REQ-028 halt=1: no new request issued; outstanding completes and is buffered; FIFO keeps draining; -> HALTED once nothing outstanding; HALTED exits only by reset.
REQ-029 imem_rvalid with nothing outstanding SHALL be ignored.

Reset
REQ-030 rst=1 SHALL immediately clear: imem_req=0, inst_valid=0, FIFO empty, outstanding=0, misalign_err=0, imem_addr=RESET_PC, inst_pc=0, inst_data=0, state REQ held inactive.
REQ-031 First rising clock edge after rst falls SHALL assert imem_req with imem_addr=RESET_PC; reset mid-transaction abandons it, late rvalid ignored per REQ-029.

Configuration
REQ-032 Macro FETCH_MISALIGN_TRAP_EN defined: redirect_target[1:0]!=0 sets misalign_err (sticky until reset), flushes, enters HALTED without fetching.
REQ-033 Macro undefined: redirect_target[1:0] forced to 0, no misalign_err port, fetch continues.

Verification
REQ-034 Reset release, 1-cycle memory returning addr as data -> imem_addr 0,4,8...; inst_pc/inst_data pairs match, one per 2 cycles.
REQ-035 inst_ready=0 for 10 cycles, DEPTH=2 -> exactly 2 entries buffered, imem_req low, no data lost, order 0,4 on release.
REQ-036 Redirect to 32'h100 while request to 8 outstanding -> response for 8 dropped, next inst_pc=32'h100.
REQ-037 halt during WAIT -> response buffered and delivered, no further imem_req, HALTED reached.
REQ-038 Macro defined, redirect to 32'h102 -> misalign_err=1 next cycle, inst_valid=0, imem_req stays 0; undefined -> fetch from 32'h100.
